// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result bundle between the datapath (master) and serial_add_ctrl (slave).
// Signals: start, a, b, c_in, sub (only when SERIAL_ADD_SUB_EN is defined) flow master->slave;
//          busy, done, sum, c_out flow slave->master.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one fa_v1 cell over WIDTH cycles, LSB first.
// Ports: clk (rising edge), reset (sync, active-high),
//        bus (serial_add_ctrl_if.slave): start/a/b/c_in[/sub] in, busy/done/sum/c_out out.
// Optional feature: SERIAL_ADD_SUB_EN adds the sub input (a - b via ~b and carry-in 1).
// fa_v1 is the combinational full-adder cell, kept here so the design file is self-contained.
module fa_v1 (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_add_ctrl_if.slave      bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             w_s0;
    logic             w_c0;

    fa_v1 u_fa (
        .sum   (w_s0),
        .c_out (w_c0),
        .a     (r_sa[0]),
        .b     (r_sb[0]),
        .c_in  (r_cy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_res <= {w_s0, r_res[WIDTH-1:1]};
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_cy  <= w_c0;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= {w_s0, r_res[WIDTH-1:1]};
                        r_c_out <= w_c0;
                    end
                end
                // IDLE, DONE and the unused encoding all accept a new start.
                default: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_sa    <= bus.a;
`ifdef SERIAL_ADD_SUB_EN
                        r_sb    <= bus.sub ? ~bus.b : bus.b;
                        r_cy    <= bus.sub | bus.c_in;
`else
                        r_sb    <= bus.b;
                        r_cy    <= bus.c_in;
`endif
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_sum   <= '0;
                        r_c_out <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.c_out = r_c_out;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against a cycle-count model.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    // Model: after an accepted start, busy for WIDTH cycles, then done with a+b+c_in.
    int             m_left = 0;
    logic           m_busy = 1'b0;
    logic           m_done = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic           m_cout = 1'b0;
    logic [WIDTH:0] m_pend = '0;

    function automatic logic [WIDTH:0] ref_result(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic ci, logic sb);
        logic [WIDTH-1:0] nb;
        nb = ~b;
        if (sb) return (WIDTH+1)'(a) + (WIDTH+1)'(nb) + (WIDTH+1)'(1);
        return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(ci);
    endfunction

    logic cur_sub;
`ifdef SERIAL_ADD_SUB_EN
    assign cur_sub = bus.sub;
`else
    assign cur_sub = 1'b0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_cout, m_sum} <= m_pend;
            end
        end else if (bus.start) begin
            m_left <= WIDTH;
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_pend <= ref_result(bus.a, bus.b, bus.c_in, cur_sub);
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("sum", 32'(bus.sum), 32'(m_sum));
            chk("c_out", 32'(bus.c_out), 32'(m_cout));
            chk("busy_and_done", 32'(bus.busy & bus.done), 32'(0));
        end
    end

    task automatic drive(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic ci, logic sb, logic st);
        bus.a = a; bus.b = b; bus.c_in = ci; bus.start = st;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sb;
`else
        if (sb) $display("sub requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    task automatic do_start(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic ci, logic sb);
        @(negedge clk);
        drive(a, b, ci, sb, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string name, output int n);
        n = 0;
        for (int i = 1; i <= 4 * WIDTH; i++) begin
            @(negedge clk);
            if (bus.done) begin n = i; return; end
        end
        chk({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic lit(string name, logic [WIDTH-1:0] s, logic c);
        chk({name, "_sum"}, 32'(bus.sum), 32'(s));
        chk({name, "_cout"}, 32'(bus.c_out), 32'(c));
        chk({name, "_model_sum"}, 32'(m_sum), 32'(s));
        chk({name, "_model_cout"}, 32'(m_cout), 32'(c));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        lit("rst", 8'h00, 1'b0);
        reset = 1'b0;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_after_rst", 32'(bus.busy), 32'(0));

        do_start(8'h00, 8'h00, 1'b0, 1'b0);
        wait_done("zero", n);
        chk("zero_latency", 32'(n), 32'(WIDTH));
        lit("zero", 8'h00, 1'b0);

        do_start(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done("ff01", n);
        lit("ff01", 8'h00, 1'b1);

        do_start(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done("ffff", n);
        lit("ffff", 8'hFF, 1'b1);

        do_start(8'h3C, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign", n);
        lit("ign", 8'h4B, 1'b0);

        do_start(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        lit("midrst", 8'h00, 1'b0);
        do_start(8'h01, 8'h01, 1'b0, 1'b0);
        wait_done("after_rst", n);
        chk("after_rst_latency", 32'(n), 32'(WIDTH));
        lit("after_rst", 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_start(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done("sub57", n);
        lit("sub57", 8'hFE, 1'b0);
        do_start(8'h07, 8'h05, 1'b0, 1'b1);
        wait_done("sub75", n);
        lit("sub75", 8'h02, 1'b1);
`endif

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
`ifdef SERIAL_ADD_SUB_EN
                  1'($urandom),
`else
                  1'b0,
`endif
                  $urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 80) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (2 * WIDTH) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
